pdm_cic_decimator: RTL and testbench
====================================

Name: pdm_cic_decimator

Overview:
- Consumes the 1-bit PDM stream captured from the Nexys4 DDR on-board microphone. Upstream the microphone runs at clk/32, about 3.125 MHz at clk = 100 MHz.
- Converts the stream to 16-bit signed PCM with a 3rd-order CIC decimator. Default decimation is 64, giving about 48.8 kHz.
- Presents samples on a valid/ready interface to downstream audio logic (FIFO, PWM playback, UART dump).

Parameters:
- DECIM, 64: decimation ratio. Power of two, range 8..256.
- OUT_W, 16: PCM output width, signed.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- pdm_bit  input  1  captured PDM data bit.
- pdm_valid  input  1  one-clk strobe; pdm_bit is valid this cycle. Spacing between strobes is at least 5 clk; nominal spacing is 32.
- pcm_data  output  OUT_W  signed PCM sample.
- pcm_valid  output  1  pcm_data holds an untaken sample.
- pcm_ready  input  1  consumer accepts the sample when pcm_valid && pcm_ready.
- overrun  output  1  sticky: a sample was overwritten before it was taken.
- overrun_clr  input  1  one-clk pulse; clears overrun.

Behaviour:
- Reset (reset = 0, asynchronous) clears the following to 0: integrators, combs, comb delay registers, decimation counter, pcm_data, pcm_valid, overrun.
  - Release is synchronous to clk.
  - Asserting reset mid-frame discards the partial frame.
  - After release, the first output needs DECIM fresh strobes.
- Input mapping: pdm_bit 1 → +1, 0 → −1, as an ACC_W-bit two's-complement value.
- Word widths:
  - ACC_W = 3*log2(DECIM) + 2. This is 20 for DECIM = 64.
  - All integrator and comb arithmetic is modulo 2^ACC_W. Wrap-around is intentional and required; no saturation inside the filter.
- Integrators:
  - 3 cascaded accumulators, updated only on a cycle with pdm_valid = 1.
  - I1 += x, I2 += I1, I3 += I2, each using pre-update register values (pipelined form).
- Decimation counter:
  - 0..DECIM−1, increments on each pdm_valid and wraps to 0.
  - The strobe that takes it from DECIM−1 to 0 raises dec_tick on the following cycle. dec_tick is internal and one clk wide.
- Comb pipeline, one stage per clk, started by dec_tick:
  - C1 = I3 − D1, D1 ← I3 (sample I3 on the dec_tick cycle).
  - C2 = C1 − D2, D2 ← C1.
  - C3 = C2 − D3, D3 ← C2.
- Scaling and output register:
  - SHIFT = 3*log2(DECIM) − (OUT_W−1).
  - pcm_next = C3 >>> SHIFT (arithmetic shift), saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Only +full-scale (+2^(3*log2 DECIM)) saturates.
- Latency: let edge E be the edge that samples the DECIM-th pdm_valid. pcm_valid rises at E+4, with pcm_data updated on the same edge.
- Handshake:
  - pcm_valid stays high and pcm_data stays stable until an edge with pcm_ready = 1.
  - At that edge pcm_valid falls, unless a new sample loads on the same edge; in that case pcm_valid stays 1 with the new data and no overrun.
- Overrun:
  - A new sample loads while pcm_valid = 1 and pcm_ready = 0 → pcm_data is overwritten with the newer sample and overrun is set.
  - overrun_clr clears overrun. If set and clear happen on the same edge, set wins.
- pdm_valid on the dec_tick cycle or during comb stages is processed normally; integrators and combs use separate registers.
- Warm-up: the first 3 output samples after reset are transient. Samples from the 4th onward are steady-state.

Decomposition:
- Package mic_pkg holds:
  - DECIM_DEFAULT, OUT_W_DEFAULT, CIC_ORDER = 3.
  - Function acc_width(decim), i.e. 3*$clog2(decim) + 2.
  - Function out_shift(decim, out_w).
  - Typedef pcm_t, a signed [OUT_W−1:0].
- One natural sub-module: cic_comb_stage. It is an ACC_W-wide registered difference with delay register and enable, instantiated 3×.
- Integrators stay inline in pdm_cic_decimator.

Test Plan:
- Constant ones: pdm_bit = 1 with a strobe every 32 clk, pcm_ready = 1 → from the 4th output onward pcm_data = 32767 (saturated). Exactly one pcm_valid pulse per 64 strobes.
- Constant zeros: pdm_bit = 0 → steady pcm_data = −32768 (0x8000), no saturation flag involvement, overrun = 0.
- Alternating 1,0,1,0: → steady pcm_data = 0.
- 75% density pattern 1110 repeated: → steady pcm_data = 16384.
- Latency/handshake: pcm_ready = 0 → pcm_valid rises exactly 4 clk after the edge sampling the 64th strobe and holds with data stable. After 64 more strobes, pcm_data takes the new value and overrun = 1. overrun_clr → overrun = 0. Raising pcm_ready then drops pcm_valid on the next edge.
- Reset mid-frame: constant ones, assert reset after strobe 40 of a frame → all outputs 0 immediately (asynchronous). After release, no pcm_valid until 64 new strobes, and the first post-reset sample equals the first post-reset sample of a clean run.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants, width helpers and the PCM sample type for the PDM
// microphone CIC decimator.
package mic_pkg;

   localparam int DECIM_DEFAULT = 64;
   localparam int OUT_W_DEFAULT = 16;
   localparam int CIC_ORDER     = 3;

   typedef logic signed [OUT_W_DEFAULT-1:0] pcm_t;

   // Accumulator width: full CIC bit growth (order*log2(R)) plus sign and
   // one guard bit so the +full-scale value is still representable.
   function automatic int acc_width(input int decim);
      return CIC_ORDER * $clog2(decim) + 2;
   endfunction

   // Right shift that maps the CIC gain R^order onto the OUT_W-bit range.
   // Negative for small ratios, in which case the result is left-shifted.
   function automatic int out_shift(input int decim, input int out_w);
      return CIC_ORDER * $clog2(decim) - (out_w - 1);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registered y = x - x_prev, evaluated once per
// decimated sample. Arithmetic wraps modulo 2^W by design.
module cic_comb_stage #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout
);

   logic [W-1:0] r_dly;
   logic [W-1:0] r_out;

   // Difference against the previous decimated input, then remember it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dly <= '0;
         r_out <= '0;
      end else if (i_en) begin
         r_out <= i_din - r_dly;
         r_dly <= i_din;
      end
   end

   assign o_dout = r_out;

endmodule

// File: rtl/pdm_cic_decimator.sv
// 1-bit PDM to signed PCM: 3rd-order CIC (inline integrators, three comb
// stages), arithmetic scaling with saturation, and a valid/ready output
// register with a sticky overrun flag.
module pdm_cic_decimator
   import mic_pkg::*;
#(
   parameter int DECIM = DECIM_DEFAULT,
   parameter int OUT_W = OUT_W_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pdm_bit,
   input  logic                    pdm_valid,
   output logic signed [OUT_W-1:0] pcm_data,
   output logic                    pcm_valid,
   input  logic                    pcm_ready,
   output logic                    overrun,
   input  logic                    overrun_clr
);

   localparam int ACC_W  = acc_width(DECIM);
   localparam int SHIFT  = out_shift(DECIM, OUT_W);
   localparam int CW     = $clog2(DECIM);
   localparam int STAGES = CIC_ORDER;
   // Scaling width: room for the accumulator or the output, plus one bit so
   // +full-scale survives a left shift before it is clamped.
   localparam int WW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam int SHR    = (SHIFT > 0) ? SHIFT : 0;
   localparam int SHL    = (SHIFT < 0) ? -SHIFT : 0;

   localparam logic signed [WW-1:0] PMAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WW-1:0] PMIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [ACC_W-1:0]        w_x;
   logic [ACC_W-1:0]        r_i1, r_i2, r_i3;
   logic [CW-1:0]           r_cnt;
   logic [STAGES:0]         r_vld_pipe;
   logic [ACC_W-1:0]        w_comb [0:STAGES];
   logic signed [WW-1:0]    w_ext;
   logic signed [WW-1:0]    w_scaled;
   logic signed [OUT_W-1:0] w_pcm_next;
   logic                    w_load;

   // PDM 1 -> +1, 0 -> -1 (all ones).
   assign w_x = pdm_bit ? {{(ACC_W-1){1'b0}}, 1'b1} : '1;

   // Pipelined integrators: each stage adds the pre-update value of the one before.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i1 <= '0;
         r_i2 <= '0;
         r_i3 <= '0;
      end else if (pdm_valid) begin
         r_i1 <= r_i1 + w_x;
         r_i2 <= r_i2 + r_i1;
         r_i3 <= r_i3 + r_i2;
      end
   end

   // Decimation counter; power-of-two ratio lets it wrap on its own.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_cnt <= '0;
      else if (pdm_valid) r_cnt <= r_cnt + CW'(1);
   end

   // Bit 0 is the decimation tick, bit k marks comb stage k output as fresh.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_vld_pipe <= '0;
      else r_vld_pipe <= {r_vld_pipe[STAGES-1:0], pdm_valid & (&r_cnt)};
   end

   assign w_comb[0] = r_i3;

   for (genvar k = 0; k < STAGES; k++) begin : g_comb
      cic_comb_stage #(.W(ACC_W)) u_comb (
         .clk    (clk),
         .reset  (reset),
         .i_en   (r_vld_pipe[k]),
         .i_din  (w_comb[k]),
         .o_dout (w_comb[k+1])
      );
   end

   // Scale the comb output into PCM range and clamp (only +full-scale clips).
   always_comb begin
      w_ext    = $signed({{(WW-ACC_W){w_comb[STAGES][ACC_W-1]}}, w_comb[STAGES]});
      w_scaled = (w_ext >>> SHR) <<< SHL;
      if (w_scaled > PMAX)      w_pcm_next = PMAX[OUT_W-1:0];
      else if (w_scaled < PMIN) w_pcm_next = PMIN[OUT_W-1:0];
      else                      w_pcm_next = w_scaled[OUT_W-1:0];
   end

   assign w_load = r_vld_pipe[STAGES];

   // Output register: a new sample always wins, overwriting an untaken one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
      end else if (w_load) begin
         pcm_data  <= w_pcm_next;
         pcm_valid <= 1'b1;
      end else if (pcm_ready) begin
         pcm_valid <= 1'b0;
      end
   end

   // Sticky overrun; a set on the same edge as a clear takes priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overrun <= 1'b0;
      else if (w_load && pcm_valid && !pcm_ready) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboarded bench for pdm_cic_decimator: stimulus pushes expected PCM
// samples, a monitor pops and compares on every accepted sample.
module tb_pdm_cic_decimator;
   import mic_pkg::*;

   localparam int DECIM = 64;
   localparam int OUT_W = 16;

   logic clk = 1'b0;
   logic reset, pdm_bit, pdm_valid, pcm_ready, overrun_clr;
   pcm_t pcm_data;
   logic pcm_valid, overrun;

   typedef struct {
      bit chk;
      int val;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_pop = 0;

   pdm_cic_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .pdm_bit     (pdm_bit),
      .pdm_valid   (pdm_valid),
      .pcm_data    (pcm_data),
      .pcm_valid   (pcm_valid),
      .pcm_ready   (pcm_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input bit chk, input int val);
      exp_t e;
      e.chk = chk;
      e.val = val;
      sbq.push_back(e);
   endtask

   // Monitor: a sample is taken at the posedge following a negedge where
   // valid && ready; compare against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && pcm_valid === 1'b1 && pcm_ready === 1'b1) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_sample: got %0d, expected no sample", pcm_data);
            end else begin
               e = sbq.pop_front();
               n_pop++;
               if (e.chk) check("pcm_data", pcm_data, e.val);
            end
         end
      end
   end

   // Called at posedge+1; the strobe is sampled by the next posedge.
   task automatic strobe(input logic b, input int gap);
      pdm_bit   = b;
      pdm_valid = 1'b1;
      @(posedge clk); #1;
      pdm_valid = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset     = 1'b0;
      pdm_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
   endtask

   // Runs nfr frames of a repeating pattern; frames 1..3 use e1..e3 (checked
   // only if known), later frames expect the steady value.
   task automatic run_frames(input string name, input logic [7:0] pat, input int plen,
                             input int nfr, input int gap, input bit known,
                             input int e1, input int e2, input int e3, input int steady);
      int p0;
      p0 = n_pop;
      for (int f = 1; f <= nfr; f++) begin
         case (f)
            1:       push(known, e1);
            2:       push(known, e2);
            3:       push(known, e3);
            default: push(1'b1, steady);
         endcase
         for (int i = 0; i < DECIM; i++) strobe(pat[((f-1)*DECIM + i) % plen], gap);
      end
      repeat (8) begin @(posedge clk); #1; end
      check({name, "_sample_count"}, n_pop - p0, nfr);
      check({name, "_queue_empty"}, sbq.size(), 0);
      check({name, "_overrun"}, overrun, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      pdm_bit     = 1'b0;
      pdm_valid   = 1'b0;
      pcm_ready   = 1'b1;
      overrun_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pcm_valid", pcm_valid, 0);
      check("reset_pcm_data", pcm_data, 0);
      check("reset_overrun", overrun, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Constant ones: C(64,3)>>3, then window differences, then +full-scale clip.
      run_frames("ones", 8'hFF, 1, 5, 32, 1'b1, 5208, 27048, 32767, 32767);
      do_reset();
      run_frames("zeros", 8'h00, 1, 5, 8, 1'b1, -5208, -27048, -32768, -32768);
      do_reset();
      run_frames("alt", 8'b0000_0001, 2, 5, 6, 1'b0, 0, 0, 0, 0);
      do_reset();
      run_frames("d75", 8'b0000_0111, 4, 5, 6, 1'b0, 0, 0, 0, 16384);

      // Latency, hold, overrun and clear with the consumer stalled.
      do_reset();
      pcm_ready = 1'b0;
      for (int i = 0; i < DECIM - 1; i++) strobe(1'b1, 6);
      pdm_bit   = 1'b1;
      pdm_valid = 1'b1;
      @(posedge clk); #1;                   // edge E
      pdm_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(posedge clk); #1;                   // E+3
      check("lat_valid_e3", pcm_valid, 0);
      @(posedge clk); #1;                   // E+4
      check("lat_valid_e4", pcm_valid, 1);
      check("lat_data_e4", pcm_data, 5208);
      repeat (5) begin @(posedge clk); #1; end
      check("hold_valid", pcm_valid, 1);
      check("hold_data", pcm_data, 5208);
      check("hold_overrun", overrun, 0);
      for (int i = 0; i < DECIM; i++) strobe(1'b1, 6);
      repeat (4) begin @(posedge clk); #1; end
      check("ovr_data", pcm_data, 27048);
      check("ovr_flag", overrun, 1);
      overrun_clr = 1'b1;
      @(posedge clk); #1;
      overrun_clr = 1'b0;
      check("ovr_clear", overrun, 0);
      push(1'b1, 27048);
      pcm_ready = 1'b1;
      @(posedge clk); #1;
      check("ready_drops_valid", pcm_valid, 0);
      check("ready_queue_empty", sbq.size(), 0);

      // Reset in the middle of a frame with a stalled sample pending.
      do_reset();
      pcm_ready = 1'b0;
      for (int i = 0; i < DECIM + 40; i++) strobe(1'b1, 6);
      for (int i = 0; i < DECIM; i++) strobe(1'b1, 6);
      check("pre_reset_overrun", overrun, 1);
      reset = 1'b0;
      #1;
      check("async_reset_valid", pcm_valid, 0);
      check("async_reset_data", pcm_data, 0);
      check("async_reset_overrun", overrun, 0);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      pcm_ready = 1'b1;
      push(1'b1, 5208);
      push(1'b1, 27048);
      push(1'b1, 32767);
      for (int i = 0; i < DECIM - 1; i++) strobe(1'b1, 6);
      check("post_reset_no_early_valid", pcm_valid, 0);
      for (int i = 0; i < 2 * DECIM + 1; i++) strobe(1'b1, 6);
      repeat (8) begin @(posedge clk); #1; end
      check("post_reset_queue_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
